hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Keeps a shadow copy of destination and control state for the EX, MEM and WB stages.
- Generates ALU operand forwarding selects, load-use stall/bubble controls, and branch/jump flush controls.
- Generalises the current pipeline top in two ways: configurable load latency and configurable branch-resolution stage, so the pipeline no longer needs NOPs in software.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_fwd_sel.sv | 33 +++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings, stage constants and shadow entry type for hazard_ctrl
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;

    // Register fields are stored at this width; narrower REG_ADDR_W is zero-extended.
    localparam int REG_ADDR_W_MAX = 8;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_W_MAX-1:0] rs;
        logic [REG_ADDR_W_MAX-1:0] rt;
        logic                      use_rs;
        logic                      use_rt;
        logic [REG_ADDR_W_MAX-1:0] dst;
        logic                      regwrite;
        logic                      is_load;
    } shadow_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - forwarding select for one ALU operand from the MEM and WB shadow entries
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W_MAX-1:0] src,
    input  logic                      use_src,
    input  shadow_t                   mem,
    input  shadow_t                   wb,
    output logic [1:0]                sel
);

    logic mem_hit;
    logic wb_hit;
    logic unused_fields;

    // A load in MEM has no data yet; the load-use stall lets it reach WB first.
    assign mem_hit = use_src && mem.regwrite && !mem.is_load
                     && (mem.dst != '0) && (mem.dst == src);
    assign wb_hit  = use_src && wb.regwrite && (wb.dst != '0) && (wb.dst == src);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

    assign unused_fields = ^{mem.valid, mem.rs, mem.rt, mem.use_rs, mem.use_rt,
                             wb.valid, wb.rs, wb.rt, wb.use_rs, wb.use_rt, wb.is_load};

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard/forwarding controller; HAZARD_PERF_EN adds perf counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int BR_STAGE   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_regwrite,
    input  logic                  id_is_load,
    input  logic                  br_taken,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_bubble,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic                  flush_exmem,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flushes
`endif
);

    localparam logic [2:0] LAT_M1    = 3'(LOAD_LAT - 1);
    localparam logic       FLUSH_MEM = (BR_STAGE == STG_MEM);

    shadow_t    ex_q;
    shadow_t    mem_q;
    shadow_t    wb_q;
    shadow_t    id_ent;
    logic [2:0] cnt_q;

    logic [REG_ADDR_W_MAX-1:0] id_rs_x;
    logic [REG_ADDR_W_MAX-1:0] id_rt_x;
    logic                      id_match;
    logic                      load_use;
    logic                      stall;
    logic [1:0]                sel_a;
    logic [1:0]                sel_b;

    assign id_rs_x = REG_ADDR_W_MAX'(id_rs);
    assign id_rt_x = REG_ADDR_W_MAX'(id_rt);

    always_comb begin
        id_ent          = '0;
        id_ent.valid    = id_valid;
        id_ent.rs       = id_rs_x;
        id_ent.rt       = id_rt_x;
        id_ent.use_rs   = id_valid && id_use_rs;
        id_ent.use_rt   = id_valid && id_use_rt;
        id_ent.dst      = REG_ADDR_W_MAX'(id_dst);
        id_ent.regwrite = id_valid && id_regwrite;
        id_ent.is_load  = id_valid && id_is_load;
    end

    assign id_match = (id_use_rs && (id_rs_x == ex_q.dst))
                   || (id_use_rt && (id_rt_x == ex_q.dst));
    assign load_use = id_valid && ex_q.is_load && (ex_q.dst != '0) && id_match;

    // The trigger cycle is the first bubble, so the counter only covers the remaining LOAD_LAT-1.
    assign stall = !br_taken && ((cnt_q != 3'd0) || load_use);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= 3'd0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= (br_taken && FLUSH_MEM) ? '0 : ex_q;
            ex_q  <= (br_taken || stall) ? '0 : id_ent;
            if (br_taken) begin
                cnt_q <= 3'd0;
            end else if (cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end else if (load_use) begin
                cnt_q <= LAT_M1;
            end
        end
    end

    hazard_fwd_sel u_fwd_a (
        .src     (ex_q.rs),
        .use_src (ex_q.use_rs),
        .mem     (mem_q),
        .wb      (wb_q),
        .sel     (sel_a)
    );

    hazard_fwd_sel u_fwd_b (
        .src     (ex_q.rt),
        .use_src (ex_q.use_rt),
        .mem     (mem_q),
        .wb      (wb_q),
        .sel     (sel_b)
    );

    assign pc_stall    = !rst && stall;
    assign ifid_stall  = !rst && stall;
    assign idex_bubble = !rst && stall;
    assign flush_ifid  = !rst && br_taken;
    assign flush_idex  = !rst && br_taken;
    assign flush_exmem = !rst && br_taken && FLUSH_MEM;
    assign fwd_a       = rst ? FWD_RF : sel_a;
    assign fwd_b       = rst ? FWD_RF : sel_b;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= 32'd0;
            perf_flushes      <= 32'd0;
        end else begin
            if (pc_stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (br_taken && (perf_flushes != 32'hFFFF_FFFF)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench: dut0 LOAD_LAT=1/BR_STAGE=3, dut1 LOAD_LAT=3/BR_STAGE=2
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_use_rs = 1'b0;
    logic       id_use_rt = 1'b0;
    logic [4:0] id_dst = '0;
    logic       id_regwrite = 1'b0;
    logic       id_is_load = 1'b0;
    logic       br_taken = 1'b0;

    logic       pc_o   [2];
    logic       ifid_o [2];
    logic       bub_o  [2];
    logic       fif_o  [2];
    logic       fie_o  [2];
    logic       fem_o  [2];
    logic [1:0] fa_o   [2];
    logic [1:0] fb_o   [2];
`ifdef HAZARD_PERF_EN
    logic [31:0] ps_o [2];
    logic [31:0] pf_o [2];
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .BR_STAGE(3)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .br_taken(br_taken),
        .pc_stall(pc_o[0]), .ifid_stall(ifid_o[0]), .idex_bubble(bub_o[0]),
        .flush_ifid(fif_o[0]), .flush_idex(fie_o[0]), .flush_exmem(fem_o[0]),
        .fwd_a(fa_o[0]), .fwd_b(fb_o[0])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cycles(ps_o[0]), .perf_flushes(pf_o[0])
`endif
    );

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .BR_STAGE(2)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .br_taken(br_taken),
        .pc_stall(pc_o[1]), .ifid_stall(ifid_o[1]), .idex_bubble(bub_o[1]),
        .flush_ifid(fif_o[1]), .flush_idex(fie_o[1]), .flush_exmem(fem_o[1]),
        .fwd_a(fa_o[1]), .fwd_b(fb_o[1])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cycles(ps_o[1]), .perf_flushes(pf_o[1])
`endif
    );

    task automatic chk(string name, int k, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    // Reference model: instructions in flight, indexed 0=EX 1=MEM 2=WB.
    typedef struct {
        bit v;
        int rs;
        int rt;
        bit urs;
        bit urt;
        int dst;
        bit rw;
        bit ld;
    } ins_t;

    ins_t pipe [2][3];
    int   trig_cyc [2] = '{-1000, -1000};
    int   lat [2] = '{1, 3};
    int   brs [2] = '{3, 2};
    int   cyc = 0;

    function automatic ins_t nop_ins();
        ins_t n;
        n = '{v: 0, rs: 0, rt: 0, urs: 0, urt: 0, dst: 0, rw: 0, ld: 0};
        return n;
    endfunction

    function automatic ins_t id_ins();
        ins_t n;
        n = nop_ins();
        if (id_valid) begin
            n = '{v: 1, rs: int'(id_rs), rt: int'(id_rt), urs: id_use_rs, urt: id_use_rt,
                  dst: int'(id_dst), rw: id_regwrite, ld: id_is_load};
        end
        return n;
    endfunction

    // Nearest older producer wins; a load still in MEM has nothing to give.
    function automatic int model_fwd(int k, int src, bit u);
        if (!u) return 0;
        for (int j = 1; j <= 2; j++) begin
            if (pipe[k][j].rw && pipe[k][j].dst != 0 && pipe[k][j].dst == src
                && !(j == 1 && pipe[k][j].ld))
                return (j == 1) ? 2 : 1;
        end
        return 0;
    endfunction

    function automatic bit model_trig(int k);
        ins_t e;
        e = pipe[k][0];
        return id_valid && e.ld && e.dst != 0 &&
               ((id_use_rs && int'(id_rs) == e.dst) || (id_use_rt && int'(id_rt) == e.dst));
    endfunction

    function automatic bit model_win(int k);
        return (cyc - trig_cyc[k]) >= 0 && (cyc - trig_cyc[k]) < lat[k];
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit tr, win, st;
            int ea, eb;
            tr  = model_trig(k);
            win = model_win(k);
            st  = !rst && !br_taken && (tr || win);
            ea  = rst ? 0 : model_fwd(k, pipe[k][0].rs, pipe[k][0].urs);
            eb  = rst ? 0 : model_fwd(k, pipe[k][0].rt, pipe[k][0].urt);
            chk("pc_stall", k, int'(pc_o[k]), int'(st));
            chk("ifid_stall", k, int'(ifid_o[k]), int'(st));
            chk("idex_bubble", k, int'(bub_o[k]), int'(st));
            chk("flush_ifid", k, int'(fif_o[k]), int'(!rst && br_taken));
            chk("flush_idex", k, int'(fie_o[k]), int'(!rst && br_taken));
            chk("flush_exmem", k, int'(fem_o[k]), int'(!rst && br_taken && brs[k] == 3));
            chk("fwd_a", k, int'(fa_o[k]), ea);
            chk("fwd_b", k, int'(fb_o[k]), eb);
            if (rst) begin
                for (int j = 0; j < 3; j++) pipe[k][j] = nop_ins();
                trig_cyc[k] = -1000;
            end else begin
                pipe[k][2] = pipe[k][1];
                pipe[k][1] = (br_taken && brs[k] == 3) ? nop_ins() : pipe[k][0];
                pipe[k][0] = (br_taken || st) ? nop_ins() : id_ins();
                if (br_taken) trig_cyc[k] = -1000;
                else if (tr && !win) trig_cyc[k] = cyc;
            end
        end
        cyc++;
    end

    task automatic step(bit v, int rs, int rt, bit urs, bit urt, int dst, bit rw, bit ld, bit br);
        @(posedge clk);
        #1;
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
        id_use_rs = urs; id_use_rt = urt; id_dst = 5'(dst);
        id_regwrite = rw; id_is_load = ld; br_taken = br;
        @(negedge clk);
        #1;
    endtask

    task automatic nops(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic all_zero(string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_stall"}, k, int'(pc_o[k] | ifid_o[k] | bub_o[k]), 0);
            chk({tag, "_flush"}, k, int'(fif_o[k] | fie_o[k] | fem_o[k]), 0);
            chk({tag, "_fwd"}, k, int'(fa_o[k] | fb_o[k]), 0);
        end
    endtask

    int stalls [2];

    initial begin
        #3;
        all_zero("reset");
        @(posedge clk); @(posedge clk);
        #1;
        rst = 1'b0;

        // add r3,r1,r2 ; sub r4,r3,r5 -> MEM forward
        step(1, 1, 2, 1, 1, 3, 1, 0, 0);
        step(1, 3, 5, 1, 1, 4, 1, 0, 0);
        nops(1);
        chk("b2b_fwd_a", 0, int'(fa_o[0]), 2);
        chk("b2b_fwd_a", 1, int'(fa_o[1]), 2);
        chk("b2b_nostall", 0, int'(pc_o[0]), 0);
        nops(2);

        // add r7 ; independent ; sub r11,r7,r5 -> WB forward
        step(1, 1, 2, 1, 1, 7, 1, 0, 0);
        step(1, 9, 10, 1, 1, 8, 1, 0, 0);
        step(1, 7, 5, 1, 1, 11, 1, 0, 0);
        nops(1);
        chk("d2_fwd_a", 0, int'(fa_o[0]), 1);
        nops(2);

        // same with dst r0 -> never forwarded
        step(1, 1, 2, 1, 1, 0, 1, 0, 0);
        step(1, 9, 10, 1, 1, 8, 1, 0, 0);
        step(1, 0, 5, 1, 1, 11, 1, 0, 0);
        nops(1);
        chk("r0_fwd_a", 0, int'(fa_o[0]), 0);
        nops(2);

        // load followed by an invalid ID slot naming r2 -> no trigger
        step(1, 1, 0, 1, 0, 2, 1, 1, 0);
        step(0, 2, 2, 1, 1, 9, 1, 0, 0);
        chk("inv_nostall", 0, int'(pc_o[0]), 0);
        chk("inv_nostall", 1, int'(pc_o[1]), 0);
        nops(3);

        // lw r2 ; add r6,r2,r7 held in ID
        stalls = '{0, 0};
        step(1, 1, 0, 1, 0, 2, 1, 1, 0);
        for (int s = 1; s <= 5; s++) begin
            if (s < 5) step(1, 2, 7, 1, 1, 6, 1, 0, 0);
            else nops(1);
            for (int k = 0; k < 2; k++) stalls[k] += int'(pc_o[k]);
            if (s == 3) chk("lu_fwd_a", 0, int'(fa_o[0]), 1);
        end
        chk("lu_stall_cycles", 0, stalls[0], 1);
        chk("lu_stall_cycles", 1, stalls[1], 3);
        nops(3);

        // taken branch flushes; flushed producers never forward
        step(1, 1, 2, 1, 1, 20, 1, 0, 0);
        step(1, 1, 2, 1, 1, 21, 1, 0, 0);
        step(1, 1, 2, 1, 1, 22, 1, 0, 1);
        chk("br_flush_ifid", 0, int'(fif_o[0]), 1);
        chk("br_flush_idex", 1, int'(fie_o[1]), 1);
        chk("br_flush_exmem", 0, int'(fem_o[0]), 1);
        chk("br_flush_exmem", 1, int'(fem_o[1]), 0);
        step(1, 21, 22, 1, 1, 23, 1, 0, 0);
        nops(1);
        chk("br_killed_fwd_a", 0, int'(fa_o[0]), 0);
        chk("br_killed_fwd_b", 0, int'(fb_o[0]), 0);
        chk("br_ex_fwd_a", 1, int'(fa_o[1]), 1);
        nops(3);

        // load-use trigger in the same cycle as br_taken -> flush wins
        step(1, 1, 0, 1, 0, 2, 1, 1, 0);
        step(1, 2, 7, 1, 1, 6, 1, 0, 1);
        for (int k = 0; k < 2; k++) begin
            chk("brlu_nostall", k, int'(pc_o[k]), 0);
            chk("brlu_flush", k, int'(fif_o[k]), 1);
        end
        nops(1);
        chk("brlu_after", 1, int'(pc_o[1]), 0);
        nops(3);

        // reset during dut1's second stall cycle
        step(1, 1, 0, 1, 0, 2, 1, 1, 0);
        step(1, 2, 7, 1, 1, 6, 1, 0, 0);
        step(1, 2, 7, 1, 1, 6, 1, 0, 0);
        chk("pre_rst_stall", 1, int'(pc_o[1]), 1);
        rst = 1'b1;
        #1;
        all_zero("rst_mid");
        @(posedge clk); @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 2, 7, 1, 1, 6, 1, 0, 0);
        chk("post_rst_nostall", 0, int'(pc_o[0]), 0);
        chk("post_rst_nostall", 1, int'(pc_o[1]), 0);
        step(1, 2, 7, 1, 1, 6, 1, 0, 0);
        chk("post_rst_nostall2", 1, int'(pc_o[1]), 0);
        nops(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
